// File: rtl/sequence_verify.sv
// -----------------------------------------------------------------------------
// sequence_verify
//
// Read-side partner of the sequence store path. A check request latches the
// user's guess, issues a single read of RAM address 0 and, once the read data
// arrives, compares the two words. The result is a one-cycle match or mismatch
// pulse. Consecutive misses use up the attempt budget. When the budget is
// exhausted the block locks out all further checks. Only a new store event
// clears the lockout and restores the attempt budget.
//
// Ports
//   clk        in   1       clock, all state updates on the rising edge
//   rst        in   1       asynchronous active-high reset
//   checkReq   in   1       verify request, only looked at while idle
//   Guess      in   WIDTH   entered sequence, captured when checkReq is accepted
//   seqStored  in   1       one-cycle pulse: a new sequence was written
//   RAM_data   in   WIDTH   RAM read data, valid RD_LAT edges after RAM_R
//   RAM_R      out  1       RAM read enable, one cycle per accepted check
//   RAM_addr   out  ADDR_W  read address, tied to 0
//   busy       out  1       a check is in flight
//   match      out  1       one-cycle pulse: guess equals stored sequence
//   mismatch   out  1       one-cycle pulse: guess differs from stored sequence
//   lockout    out  1       level: attempts exhausted, checks refused
//   tries_left out  TRY_W   attempts remaining before lockout
// -----------------------------------------------------------------------------
module sequence_verify #(
  parameter int WIDTH     = 20,
  parameter int ADDR_W    = 5,
  parameter int RD_LAT    = 1,
  parameter int MAX_TRIES = 3,
  parameter int TRY_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              checkReq,
  input  logic [WIDTH-1:0]  Guess,
  input  logic              seqStored,
  input  logic [WIDTH-1:0]  RAM_data,
  output logic              RAM_R,
  output logic [ADDR_W-1:0] RAM_addr,
  output logic              busy,
  output logic              match,
  output logic              mismatch,
  output logic              lockout,
  output logic [TRY_W-1:0]  tries_left
);

  // State encoding. All four codes are used, and the default arm still steers
  // any corrupted value back to idle.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_LOCK = 2'd3;

  // Latency counter holds RD_LAT-1 at most. RD_LAT is limited to 1..4, so two
  // bits are enough.
  localparam int               CNT_W      = 2;
  localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(RD_LAT - 1);
  localparam logic [TRY_W-1:0] TRIES_FULL = TRY_W'(MAX_TRIES);

  // The attempt counter saturates at zero and never wraps.
  function automatic logic [TRY_W-1:0] dec_sat(input logic [TRY_W-1:0] t);
    if (t == '0) begin
      return '0;
    end
    return t - TRY_W'(1);
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] lat_cnt;
  logic [WIDTH-1:0] guess_p0;
  logic [TRY_W-1:0] tries_dec;
  logic             rd_done;
  logic             hit;

  assign RAM_addr  = '0;
  assign tries_dec = dec_sat(tries_left);
  assign rd_done   = (lat_cnt == '0);
  assign hit       = (RAM_data == guess_p0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      RAM_R      <= 1'b0;
      busy       <= 1'b0;
      match      <= 1'b0;
      mismatch   <= 1'b0;
      lockout    <= 1'b0;
      tries_left <= TRIES_FULL;
      guess_p0   <= '0;
      lat_cnt    <= '0;
    end else begin
      // Result pulses last exactly one cycle unless they are re-asserted below.
      match    <= 1'b0;
      mismatch <= 1'b0;

      if (seqStored) begin
        // A fresh store overrides everything. Any in-flight check is dropped
        // silently, and a request arriving on the same edge is ignored.
        tries_left <= TRIES_FULL;
        lockout    <= 1'b0;
        RAM_R      <= 1'b0;
        busy       <= 1'b0;
        state      <= ST_IDLE;
      end else begin
        case (state)
          // Stage p0: accept request, capture guess, issue the read.
          ST_IDLE: begin
            if (checkReq) begin
              guess_p0 <= Guess;
              RAM_R    <= 1'b1;
              busy     <= 1'b1;
              state    <= ST_READ;
            end
          end

          // Stage p1: the RAM has sampled the read. Start counting its latency.
          ST_READ: begin
            RAM_R   <= 1'b0;
            lat_cnt <= LAT_LOAD;
            state   <= ST_WAIT;
          end

          // Stage p2: read data is valid. Compare it and update the budget.
          ST_WAIT: begin
            if (rd_done) begin
              busy <= 1'b0;
              if (hit) begin
                match      <= 1'b1;
                tries_left <= TRIES_FULL;
                state      <= ST_IDLE;
              end else begin
                mismatch   <= 1'b1;
                tries_left <= tries_dec;
                if (tries_dec == '0) begin
                  lockout <= 1'b1;
                  state   <= ST_LOCK;
                end else begin
                  state <= ST_IDLE;
                end
              end
            end else begin
              lat_cnt <= lat_cnt - CNT_W'(1);
            end
          end

          ST_LOCK: begin
            RAM_R   <= 1'b0;
            busy    <= 1'b0;
            lockout <= 1'b1;
          end

          default: begin
            RAM_R <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sequence_verify.sv
// -----------------------------------------------------------------------------
// tb_sequence_verify
//
// Drives two sequence_verify instances (read latency 1 and 3) from one shared
// stimulus stream. Each instance has its own RAM model. The RAM model returns
// the stored word only in the cycle in which it is due; at any other time it
// returns junk. A transaction-level model predicts every output, and a
// negedge process compares the model against both instances on every cycle.
// Directed scenarios add literal expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_sequence_verify;
  localparam int WIDTH     = 20;
  localparam int ADDR_W    = 5;
  localparam int MAX_TRIES = 3;
  localparam int TRY_W     = 2;
  localparam int LAT0      = 1;
  localparam int LAT1      = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic checkReq = 1'b0;
  logic seqStored = 1'b0;
  logic [WIDTH-1:0] Guess = '0;
  logic [WIDTH-1:0] stored = '0;

  logic [WIDTH-1:0]  ram_d0, ram_d1;
  logic [1:0]        ram_r, busy, match, mismatch, lockout;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [TRY_W-1:0]  tries0, tries1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  sequence_verify #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .RD_LAT(LAT0),
                    .MAX_TRIES(MAX_TRIES), .TRY_W(TRY_W)) dut0 (
    .clk(clk), .rst(rst), .checkReq(checkReq), .Guess(Guess),
    .seqStored(seqStored), .RAM_data(ram_d0), .RAM_R(ram_r[0]),
    .RAM_addr(addr0), .busy(busy[0]), .match(match[0]),
    .mismatch(mismatch[0]), .lockout(lockout[0]), .tries_left(tries0));

  sequence_verify #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .RD_LAT(LAT1),
                    .MAX_TRIES(MAX_TRIES), .TRY_W(TRY_W)) dut1 (
    .clk(clk), .rst(rst), .checkReq(checkReq), .Guess(Guess),
    .seqStored(seqStored), .RAM_data(ram_d1), .RAM_R(ram_r[1]),
    .RAM_addr(addr1), .busy(busy[1]), .match(match[1]),
    .mismatch(mismatch[1]), .lockout(lockout[1]), .tries_left(tries1));

  // RAM models: {valid, data} travels down a delay line of RD_LAT stages.
  logic [WIDTH:0] rp0  = '0;
  logic [WIDTH:0] rp1a = '0;
  logic [WIDTH:0] rp1b = '0;
  logic [WIDTH:0] rp1c = '0;
  always @(posedge clk) begin
    rp0  <= {ram_r[0], stored};
    rp1a <= {ram_r[1], stored};
    rp1b <= rp1a;
    rp1c <= rp1b;
  end
  assign ram_d0 = rp0[WIDTH]  ? rp0[WIDTH-1:0]  : ~stored;
  assign ram_d1 = rp1c[WIDTH] ? rp1c[WIDTH-1:0] : ~stored;

  // Transaction model: one pending check per instance, resolved a fixed
  // number of edges after acceptance.
  int               cyc = 0;
  bit               m_pend  [2] = '{0, 0};
  int               m_acc   [2] = '{0, 0};
  logic [WIDTH-1:0] m_guess [2] = '{'0, '0};
  int               m_tries [2] = '{MAX_TRIES, MAX_TRIES};
  bit               m_lock  [2] = '{0, 0};
  bit               m_match [2] = '{0, 0};
  bit               m_mism  [2] = '{0, 0};

  function automatic int lat_of(int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic void model_reset(int i);
    m_pend[i]  = 0;
    m_tries[i] = MAX_TRIES;
    m_lock[i]  = 0;
    m_match[i] = 0;
    m_mism[i]  = 0;
  endfunction

  function automatic void model_step(int i);
    m_match[i] = 0;
    m_mism[i]  = 0;
    if (seqStored) begin
      m_pend[i]  = 0;
      m_tries[i] = MAX_TRIES;
      m_lock[i]  = 0;
    end else if (m_pend[i]) begin
      if (cyc == m_acc[i] + 1 + lat_of(i)) begin
        m_pend[i] = 0;
        if (m_guess[i] == stored) begin
          m_match[i] = 1;
          m_tries[i] = MAX_TRIES;
        end else begin
          m_mism[i] = 1;
          if (m_tries[i] > 0) m_tries[i] = m_tries[i] - 1;
          if (m_tries[i] == 0) m_lock[i] = 1;
        end
      end
    end else if (!m_lock[i] && checkReq) begin
      m_pend[i]  = 1;
      m_acc[i]   = cyc;
      m_guess[i] = Guess;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) model_reset(i);
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_pend[i]));
      chk($sformatf("ram_r%0d", i), 32'(ram_r[i]),
          32'(m_pend[i] && (cyc == m_acc[i])));
      chk($sformatf("addr%0d", i), 32'((i == 0) ? addr0 : addr1), 32'd0);
      chk($sformatf("match%0d", i), 32'(match[i]), 32'(m_match[i]));
      chk($sformatf("mismatch%0d", i), 32'(mismatch[i]), 32'(m_mism[i]));
      chk($sformatf("lockout%0d", i), 32'(lockout[i]), 32'(m_lock[i]));
      chk($sformatf("tries%0d", i), 32'((i == 0) ? tries0 : tries1),
          32'(m_tries[i]));
    end
  end

  task automatic store(input logic [WIDTH-1:0] v);
    @(negedge clk);
    seqStored = 1'b1;
    stored    = v;
    @(negedge clk);
    seqStored = 1'b0;
  endtask

  task automatic request(input logic [WIDTH-1:0] g);
    @(negedge clk);
    checkReq = 1'b1;
    Guess    = g;
    @(negedge clk);
    checkReq = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, errors so far %0d", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, n1, r0, r1, f0, f1;
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ram_r", 32'(ram_r), 32'd0);
    chk("rst_tries0", 32'(tries0), 32'd3);
    chk("rst_lockout", 32'(lockout), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Correct guess with read latency 1.
    store(20'hABCDE);
    request(20'hABCDE);
    chk("t1_ram_r_hi", 32'(ram_r[0]), 32'd1);
    chk("t1_addr", 32'(addr0), 32'd0);
    chk("t1_busy", 32'(busy[0]), 32'd1);
    step(1);
    chk("t1_ram_r_lo", 32'(ram_r[0]), 32'd0);
    chk("t1_no_early", 32'(match[0]), 32'd0);
    step(1);
    chk("t1_match", 32'(match[0]), 32'd1);
    chk("t1_mism", 32'(mismatch[0]), 32'd0);
    chk("t1_tries", 32'(tries0), 32'd3);
    step(1);
    chk("t1_pulse_end", 32'(match[0]), 32'd0);
    step(2);

    // Three misses exhaust the budget.
    store(20'h12345);
    for (int k = 1; k <= 3; k++) begin
      request(20'h12344);
      step(2);
      chk($sformatf("t2_mism_%0d", k), 32'(mismatch[0]), 32'd1);
      chk($sformatf("t2_tries_%0d", k), 32'(tries0), 32'(3 - k));
      step(3);
    end
    chk("t2_lock0", 32'(lockout[0]), 32'd1);
    chk("t2_lock1", 32'(lockout[1]), 32'd1);
    chk("t2_tries1", 32'(tries1), 32'd0);
    request(20'h12345);
    for (int k = 0; k < 5; k++) begin
      chk("t2_locked_ram_r", 32'(ram_r), 32'd0);
      chk("t2_locked_pulse", 32'(match | mismatch), 32'd0);
      step(1);
    end

    // A store clears the lockout.
    store(20'h12345);
    chk("t3_unlock", 32'(lockout[0]), 32'd0);
    chk("t3_tries", 32'(tries0), 32'd3);
    request(20'h12345);
    step(2);
    chk("t3_match", 32'(match[0]), 32'd1);
    step(3);

    // A store right after acceptance aborts the check.
    @(negedge clk);
    checkReq = 1'b1;
    Guess    = stored;
    @(negedge clk);
    checkReq  = 1'b0;
    seqStored = 1'b1;
    @(negedge clk);
    seqStored = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ram_r", 32'(ram_r[0]), 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("t4_no_pulse", 32'(match | mismatch), 32'd0);
      step(1);
    end
    // A store on the same edge as a request drops the request.
    @(negedge clk);
    checkReq  = 1'b1;
    seqStored = 1'b1;
    @(negedge clk);
    checkReq  = 1'b0;
    seqStored = 1'b0;
    chk("t4_drop_ram_r", 32'(ram_r), 32'd0);
    chk("t4_drop_busy", 32'(busy), 32'd0);
    step(2);

    // Request held high: one check per acceptance.
    n0 = 0; n1 = 0; r0 = 0; r1 = 0; f0 = -1; f1 = -1;
    @(negedge clk);
    checkReq = 1'b1;
    Guess    = stored;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (match[0]) begin n0++; if (f0 < 0) f0 = k; end
      if (match[1]) begin n1++; if (f1 < 0) f1 = k; end
      r0 += int'(ram_r[0]);
      r1 += int'(ram_r[1]);
      if (k == 10) checkReq = 1'b0;
    end
    chk("t5_first_lat1", 32'(f0), 32'd2);
    chk("t5_first_lat3", 32'(f1), 32'd4);
    chk("t5_matches_lat1", 32'(n0), 32'd4);
    chk("t5_matches_lat3", 32'(n1), 32'd3);
    chk("t5_reads_lat1", 32'(r0), 32'd4);
    chk("t5_reads_lat3", 32'(r1), 32'd3);
    step(2);

    // Asynchronous reset between edges while a check is in flight.
    request(stored ^ 20'h00001);
    step(4);
    chk("t6_pre_tries", 32'(tries1), 32'd2);
    request(stored);
    step(1);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ram_r", 32'(ram_r), 32'd0);
    chk("t6_pulse", 32'(match | mismatch), 32'd0);
    chk("t6_tries0", 32'(tries0), 32'd3);
    chk("t6_tries1", 32'(tries1), 32'd3);
    @(negedge clk);
    #2 rst = 1'b0;

    // Randomized traffic.
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      checkReq  = ($urandom_range(0, 9) < 5);
      seqStored = ($urandom_range(0, 29) == 0);
      if (seqStored) stored = WIDTH'($urandom);
      if ($urandom_range(0, 1) == 1) Guess = stored;
      else Guess = stored ^ (20'd1 << $urandom_range(0, WIDTH - 1));
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #4 rst = 1'b0;
      end
    end
    @(negedge clk);
    checkReq  = 1'b0;
    seqStored = 1'b0;
    step(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
